// File: rtl/seg7_scan_peripheral.sv
// Bus-mapped multi-digit 7-segment controller with autonomous scan,
// per-digit decimal points, leading-zero blanking and registered readback.
module seg7_scan_peripheral #(
    parameter logic [7:0] BASE_ADDR   = 8'hD0,
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 50000,
    parameter bit         ACTIVE_LOW  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            BUS_ADDR,
    input  logic [7:0]            BUS_DATA,
    input  logic                  BUS_WE,
    output logic [7:0]            BUS_DATA_OUT,
    output logic                  BUS_DATA_OE,
    output logic [7:0]            HEX_OUT,
    output logic [NUM_DIGITS-1:0] SEG_SELECT
);

    localparam int NB = NUM_DIGITS / 2;
    localparam int VW = 4 * NUM_DIGITS;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [VW-1:0]         value;
    logic [NUM_DIGITS-1:0] dp;
    logic [1:0]            ctrl;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;

    logic [8:0] addr9;
    logic [7:0] off;
    logic       mapped;
    logic [7:0] rd_data;

    logic [3:0]            nib;
    logic [VW-1:0]         higher;
    logic                  blank;
    logic [6:0]            seg;
    logic [7:0]            hex_ah;
    logic [NUM_DIGITS-1:0] sel_ah;
    logic [7:0]            hex_nx;
    logic [NUM_DIGITS-1:0] sel_nx;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // 9-bit compare keeps the window from wrapping past 8'hFF
    assign addr9  = {1'b0, BUS_ADDR};
    assign off    = BUS_ADDR - BASE_ADDR;
    assign mapped = (addr9 >= {1'b0, BASE_ADDR}) &&
                    (addr9 <= ({1'b0, BASE_ADDR} + 9'(NB + 1)));

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NB; k++) begin
            if (off == 8'(k)) rd_data = value[VW-1-8*k -: 8];
        end
        if (off == 8'(NB))     rd_data = 8'(dp);
        if (off == 8'(NB + 1)) rd_data = {6'b0, ctrl};
    end

    // A digit blanks when it and every more significant nibble are zero
    always_comb begin
        nib    = value[{idx, 2'b00} +: 4];
        higher = value >> {idx, 2'b00};
        blank  = ctrl[1] && (idx != '0) && (higher == '0);
        seg    = blank ? 7'h00 : decode(nib);
        hex_ah = {dp[idx], seg};
        sel_ah = NUM_DIGITS'(1) << idx;
        if (!ctrl[0]) begin
            hex_ah = 8'h00;
            sel_ah = '0;
        end
        hex_nx = ACTIVE_LOW ? ~hex_ah : hex_ah;
        sel_nx = ACTIVE_LOW ? ~sel_ah : sel_ah;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            value        <= '0;
            dp           <= '0;
            ctrl         <= 2'b01;
            cnt          <= '0;
            idx          <= '0;
            BUS_DATA_OUT <= 8'h00;
            BUS_DATA_OE  <= 1'b0;
            HEX_OUT      <= ACTIVE_LOW ? 8'hFF : 8'h00;
            SEG_SELECT   <= ACTIVE_LOW ? '1 : '0;
        end else begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (BUS_WE && mapped) begin
                for (int k = 0; k < NB; k++) begin
                    if (off == 8'(k)) value[VW-1-8*k -: 8] <= BUS_DATA;
                end
                if (off == 8'(NB))     dp   <= BUS_DATA[NUM_DIGITS-1:0];
                if (off == 8'(NB + 1)) ctrl <= BUS_DATA[1:0];
            end

            BUS_DATA_OE  <= !BUS_WE && mapped;
            BUS_DATA_OUT <= (!BUS_WE && mapped) ? rd_data : 8'h00;
            HEX_OUT      <= hex_nx;
            SEG_SELECT   <= sel_nx;
        end
    end

endmodule

// File: tb/tb_seg7_scan_peripheral.sv
// Self-checking bench for seg7_scan_peripheral: directed steps plus
// random bus traffic against a behavioural display model.
module tb_seg7_scan_peripheral;

    localparam logic [7:0] BASE = 8'hD0;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int NB = ND / 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00;
    logic [7:0] BUS_DATA = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [7:0] BUS_DATA_OUT;
    logic       BUS_DATA_OE;
    logic [7:0] HEX_OUT;
    logic [ND-1:0] SEG_SELECT;

    int tests = 0;
    int fails = 0;

    // model state
    logic [4*ND-1:0] m_val;
    logic [ND-1:0]   m_dp;
    logic [1:0]      m_ctrl;
    int              n;

    logic [7:0] codes [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_scan_peripheral #(
        .BASE_ADDR(BASE), .NUM_DIGITS(ND),
        .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE),
        .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_DATA_OE(BUS_DATA_OE),
        .HEX_OUT(HEX_OUT), .SEG_SELECT(SEG_SELECT)
    );

    always #5 CLK = ~CLK;

    function automatic bit is_mapped(input logic [7:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + NB + 1);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int k;
        k = int'(a) - int'(BASE);
        if (k < NB) return 8'((m_val >> (8 * (NB - 1 - k))) & 'hFF);
        if (k == NB) return 8'(m_dp);
        return {6'b0, m_ctrl};
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        int k;
        int sh;
        k = int'(a) - int'(BASE);
        if (k < NB) begin
            sh = 8 * (NB - 1 - k);
            m_val = (m_val & ~(16'hFF << sh)) | (16'(d) << sh);
        end else if (k == NB) begin
            m_dp = d[ND-1:0];
        end else begin
            m_ctrl = d[1:0];
        end
    endtask

    task automatic m_disp(output logic [7:0] h, output logic [ND-1:0] s);
        int i;
        int nibv;
        bit blk;
        i = (n / RD) % ND;
        nibv = int'((m_val >> (4 * i)) & 16'hF);
        blk = m_ctrl[1] && (i > 0) && ((m_val >> (4 * i)) == 0);
        h = blk ? 8'hFF : codes[nibv];
        if (m_dp[i]) h[7] = 1'b0;
        s = ~(ND'(1) << i);
        if (!m_ctrl[0]) begin
            h = 8'hFF;
            s = '1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic we, input logic [7:0] a,
                        input logic [7:0] d);
        logic [7:0] eh;
        logic [ND-1:0] es;
        logic eo;
        logic [7:0] ed;
        BUS_WE = we;
        BUS_ADDR = a;
        BUS_DATA = d;
        m_disp(eh, es);
        eo = !we && is_mapped(a);
        ed = eo ? m_read(a) : 8'h00;
        @(posedge CLK);
        if (we && is_mapped(a)) m_write(a, d);
        n++;
        #1;
        chk("hex", HEX_OUT, eh);
        chk("sel", 8'(SEG_SELECT), 8'(es));
        chk("oe", 8'(BUS_DATA_OE), 8'(eo));
        chk("dout", BUS_DATA_OUT, ed);
        BUS_WE = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        RESET = 1'b1;
        BUS_WE = 1'b0;
        repeat (cycles) @(posedge CLK);
        m_val = '0;
        m_dp = '0;
        m_ctrl = 2'b01;
        n = 0;
        #1;
        chk("rst_hex", HEX_OUT, 8'hFF);
        chk("rst_sel", 8'(SEG_SELECT), 8'h0F);
        chk("rst_oe", 8'(BUS_DATA_OE), 8'h00);
        chk("rst_dout", BUS_DATA_OUT, 8'h00);
        RESET = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) tick(1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        n = 0;
        m_val = '0;
        m_dp = '0;
        m_ctrl = 2'b01;
        #1;
        do_reset(3);

        tick(1'b0, BASE + 8'd3, 8'h00);
        tick(1'b0, BASE + 8'd2, 8'h00);
        tick(1'b1, BASE + 8'd0, 8'h12);
        tick(1'b1, BASE + 8'd1, 8'h34);
        idle(2 * RD * ND);

        tick(1'b1, BASE + 8'd2, 8'h05);
        tick(1'b0, BASE + 8'd2, 8'h00);
        idle(RD * ND);

        tick(1'b1, BASE + 8'd0, 8'h00);
        tick(1'b1, BASE + 8'd1, 8'h07);
        tick(1'b1, BASE + 8'd3, 8'h03);
        idle(RD * ND + 3);
        tick(1'b1, BASE + 8'd2, 8'h00);
        idle(RD * ND);

        tick(1'b1, BASE + 8'd3, 8'h00);
        idle(RD * ND);
        tick(1'b1, BASE + 8'd3, 8'h01);
        idle(RD * ND);
        tick(1'b1, 8'hE0, 8'hAA);
        tick(1'b0, 8'hE0, 8'h00);
        tick(1'b1, BASE + 8'd4, 8'h55);
        tick(1'b0, BASE + 8'd4, 8'h00);
        tick(1'b0, BASE - 8'd1, 8'h00);
        tick(1'b0, BASE + 8'd1, 8'h00);

        // reset partway through digit 2 of the scan
        while (!(((n / RD) % ND) == 2 && (n % RD) == 1)) idle(1);
        do_reset(1);
        idle(RD + 1);

        for (int r = 0; r < 400; r++) begin
            logic [7:0] a;
            logic [7:0] d;
            logic we;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            else a = BASE + 8'($urandom_range(0, NB + 2));
            d = 8'($urandom);
            if (a == BASE + 8'(NB + 1) && we && $urandom_range(0, 3) != 0)
                d[0] = 1'b1;
            tick(we, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
